// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared constants and types for the pooling window feeder
package pool_pkg;

    localparam int DEFAULT_KERNAL_SIZE = 2;
    localparam int DEFAULT_DEPTH       = 8;
    localparam int DEFAULT_DATA_WIDTH  = 16;

    typedef logic [DEFAULT_DEPTH*DEFAULT_DATA_WIDTH-1:0] neuron_t;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } feeder_state_t;

endpackage

// File: rtl/pool_band_buffer.sv
// rtl/pool_band_buffer.sv - single-write/single-read band storage with combinational read
module pool_band_buffer
    import pool_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_DEPTH * DEFAULT_DATA_WIDTH,
    parameter int ENTRIES = 16,
    localparam int ADDR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [ENTRIES];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pool_window_feeder.sv
// rtl/pool_window_feeder.sv - buffers a band of rows and replays it window by window
module pool_window_feeder
    import pool_pkg::*;
#(
    parameter int KERNAL_SIZE = DEFAULT_KERNAL_SIZE,
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int MAP_WIDTH   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DEPTH*DATA_WIDTH-1:0]   in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [DEPTH*DATA_WIDTH-1:0]   neuron_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [KERNAL_SIZE**2-1:0]     count,
    output logic                          win_last
);

    localparam int VEC_W   = DEPTH * DATA_WIDTH;
    localparam int ENTRIES = KERNAL_SIZE * MAP_WIDTH;
    localparam int ADDR_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int NUM_WIN = MAP_WIDTH / KERNAL_SIZE;
    localparam int K_W     = (KERNAL_SIZE > 1) ? $clog2(KERNAL_SIZE) : 1;
    localparam int WIN_W   = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
    localparam int CNT_W   = KERNAL_SIZE ** 2;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ENTRIES - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(MAP_WIDTH);
    localparam logic [ADDR_W-1:0] WIN_STEP  = ADDR_W'(KERNAL_SIZE);
    localparam logic [K_W-1:0]    K_LAST    = K_W'(KERNAL_SIZE - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(NUM_WIN - 1);
    localparam logic [CNT_W-1:0]  ELEM_LAST = CNT_W'(KERNAL_SIZE * KERNAL_SIZE - 1);

    generate
        if ((KERNAL_SIZE < 1) || (MAP_WIDTH % KERNAL_SIZE != 0)) begin : g_bad_map_width
            $error("MAP_WIDTH must be a non-zero multiple of KERNAL_SIZE");
        end
    endgenerate

    feeder_state_t     state_q, state_d;
    logic [ADDR_W-1:0] fill_addr_q;
    logic [K_W-1:0]    c_q, r_q;
    logic [WIN_W-1:0]  win_q;
    logic [ADDR_W-1:0] row_base_q, win_base_q;
    logic [CNT_W-1:0]  elem_q;
    logic              drain_done_q;
    logic              fill_we;
    logic              issue;
    logic [ADDR_W-1:0] rd_addr;
    logic [VEC_W-1:0]  rd_data;

    // row_base/win_base track r*MAP_WIDTH and win*K incrementally, so no multiplier
    assign rd_addr = row_base_q + win_base_q + ADDR_W'(c_q);

    pool_band_buffer #(
        .WIDTH   (VEC_W),
        .ENTRIES (ENTRIES)
    ) u_band_buffer (
        .clk     (clk),
        .wr_en   (fill_we),
        .wr_addr (fill_addr_q),
        .wr_data (in_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // The first element is issued alongside the final fill beat so out_valid rises with DRAIN
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        fill_we  = 1'b0;
        issue    = 1'b0;
        case (state_q)
            FILL: begin
                in_ready = 1'b1;
                fill_we  = in_valid;
                if (in_valid && (fill_addr_q == LAST_ADDR)) begin
                    state_d = DRAIN;
                    issue   = 1'b1;
                end
            end
            DRAIN: begin
                if (!drain_done_q && (!out_valid || out_ready)) begin
                    issue = 1'b1;
                end
                if (drain_done_q && out_valid && out_ready) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fill_addr_q  <= '0;
            c_q          <= '0;
            r_q          <= '0;
            win_q        <= '0;
            row_base_q   <= '0;
            win_base_q   <= '0;
            elem_q       <= '0;
            drain_done_q <= 1'b0;
            out_valid    <= 1'b0;
            win_last     <= 1'b0;
            count        <= '0;
            neuron_out   <= '0;
        end else begin
            if (fill_we) begin
                fill_addr_q <= (fill_addr_q == LAST_ADDR) ? '0 : fill_addr_q + ADDR_W'(1);
            end
            if ((state_q == DRAIN) && (state_d == FILL)) begin
                drain_done_q <= 1'b0;
            end
            if (issue) begin
                neuron_out <= rd_data;
                count      <= elem_q + CNT_W'(1);
                win_last   <= (elem_q == ELEM_LAST);
                out_valid  <= 1'b1;
                elem_q     <= (elem_q == ELEM_LAST) ? '0 : elem_q + CNT_W'(1);
                if (c_q == K_LAST) begin
                    c_q <= '0;
                    if (r_q == K_LAST) begin
                        r_q        <= '0;
                        row_base_q <= '0;
                        if (win_q == WIN_LAST) begin
                            win_q        <= '0;
                            win_base_q   <= '0;
                            drain_done_q <= 1'b1;
                        end else begin
                            win_q      <= win_q + WIN_W'(1);
                            win_base_q <= win_base_q + WIN_STEP;
                        end
                    end else begin
                        r_q        <= r_q + K_W'(1);
                        row_base_q <= row_base_q + ROW_STEP;
                    end
                end else begin
                    c_q <= c_q + K_W'(1);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pool_window_feeder.sv
// tb/tb_pool_window_feeder.sv - scoreboard bench for pool_window_feeder
module tb_pool_window_feeder;

    localparam int K     = 2;
    localparam int DEPTH = 8;
    localparam int DW    = 16;
    localparam int MW    = 4;
    localparam int VW    = DEPTH * DW;
    localparam int BAND  = K * MW;
    localparam int PERM [BAND] = '{0, 1, 4, 5, 2, 3, 6, 7};
    localparam int CNT  [BAND] = '{1, 2, 3, 4, 1, 2, 3, 4};

    typedef struct packed {
        logic [VW-1:0] data;
        logic [3:0]    cnt;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [VW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [VW-1:0] neuron_out;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [3:0]    count;
    logic          win_last;

    always #5 clk = ~clk;

    pool_window_feeder #(
        .KERNAL_SIZE (K),
        .DEPTH       (DEPTH),
        .DATA_WIDTH  (DW),
        .MAP_WIDTH   (MW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .neuron_out (neuron_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .count      (count),
        .win_last   (win_last)
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   hs_total = 0;
    int   exp_hs = 0;
    int   stim_timeouts = 0;
    bit   toggle_mode = 1'b0;
    bit   done = 1'b0;
    int   cyc = 0;

    function automatic logic [VW-1:0] mk(input int v);
        logic [VW-1:0] w;
        for (int i = 0; i < DEPTH; i++) begin
            w[i*DW +: DW] = 16'(32'h1000 * i + v);
        end
        return w;
    endfunction

    // out_ready pattern 1,0,0,1 when toggling, otherwise held high
    always @(posedge clk) begin
        cyc <= cyc + 1;
        #1;
        out_ready = toggle_mode ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
    end

    task automatic push_band(input int base);
        for (int i = 0; i < BAND; i++) begin
            exp_q.push_back('{mk(base + PERM[i]), 4'(CNT[i]), (CNT[i] == K * K)});
        end
    endtask

    task automatic feed(input int base, input int n, input bit keep);
        for (int i = 0; i < n; i++) begin
            int waited;
            waited = 0;
            in_data  = mk(base + i);
            in_valid = 1'b1;
            do begin
                @(negedge clk);
                waited++;
            end while (!in_ready && waited < 200);
            if (!in_ready) stim_timeouts++;
            @(posedge clk);
            #1;
        end
        if (!keep) begin
            in_valid = 1'b0;
            in_data  = '0;
        end
    endtask

    task automatic wait_drained();
        int waited;
        waited = 0;
        do begin
            @(negedge clk);
            #1;
            waited++;
        end while (!(exp_q.size() == 0 && !out_valid && in_ready) && waited < 300);
        if (waited >= 300) stim_timeouts++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        // in-order band, out_ready high
        push_band(1);
        feed(1, BAND, 1'b0);
        wait_drained();
        // same band under 1,0,0,1 backpressure
        toggle_mode = 1'b1;
        push_band(1);
        feed(1, BAND, 1'b0);
        wait_drained();
        toggle_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // back-to-back bands with in_valid held high
        push_band(1);
        push_band(9);
        feed(1, BAND, 1'b1);
        feed(9, BAND, 1'b0);
        wait_drained();
        // reset mid-fill discards the partial band
        feed(40, 3, 1'b0);
        do_reset();
        push_band(20);
        feed(20, BAND, 1'b0);
        wait_drained();
        // reset mid-drain after five outputs
        begin
            int hs0;
            int waited;
            hs0 = hs_total;
            waited = 0;
            push_band(30);
            feed(30, BAND, 1'b0);
            do begin
                @(negedge clk);
                #1;
                waited++;
            end while (hs_total < hs0 + 5 && waited < 200);
            if (waited >= 200) stim_timeouts++;
            @(posedge clk);
            #1;
            do_reset();
        end
        push_band(50);
        feed(50, BAND, 1'b0);
        wait_drained();
        exp_hs = 8 + 8 + 16 + 8 + 5 + 8;
        done = 1'b1;
        repeat (20) @(posedge clk);
        $display("FAIL monitor_finish: got no summary, required summary");
        $fatal(1);
    end

    exp_t          e;
    bit            prev_reset = 1'b1;
    bit            have_prev = 1'b0;
    bit            prev_valid, prev_ready, prev_last;
    logic [VW-1:0] prev_data;
    logic [3:0]    prev_count;
    bit            last_fill_prev = 1'b0;
    int            fill_beats = 0;
    int            stall_run = -1;
    bit            run_tog = 1'b0;
    int            mon_cyc = 0;

    task automatic chk(input bit ok, input string name,
                       input logic [135:0] act, input logic [135:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        mon_cyc++;
        if (reset) begin
            exp_q.delete();
            have_prev      = 1'b0;
            fill_beats     = 0;
            last_fill_prev = 1'b0;
            stall_run      = -1;
            run_tog        = 1'b0;
        end else begin
            if (prev_reset) begin
                chk(out_valid == 1'b0, "reset_out_valid", 136'(out_valid), 136'(0));
                chk(count == 4'd0, "reset_count", 136'(count), 136'(0));
                chk(win_last == 1'b0, "reset_win_last", 136'(win_last), 136'(0));
                chk(neuron_out == '0, "reset_neuron_out", 136'(neuron_out), 136'(0));
                chk(in_ready == 1'b1, "reset_in_ready", 136'(in_ready), 136'(1));
            end
            if (last_fill_prev) begin
                chk(out_valid == 1'b1, "first_valid_latency", 136'(out_valid), 136'(1));
            end
            if (in_ready) begin
                chk(out_valid == 1'b0, "no_output_in_fill", 136'(out_valid), 136'(0));
            end
            if (have_prev && prev_valid && !prev_ready) begin
                chk(out_valid && neuron_out == prev_data && count == prev_count &&
                    win_last == prev_last, "stall_hold",
                    {neuron_out, count, win_last, out_valid},
                    {prev_data, prev_count, prev_last, 1'b1});
            end
            if (out_valid && out_ready) begin
                hs_total++;
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_output", 136'(neuron_out), 136'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk(neuron_out == e.data, "neuron_out", 136'(neuron_out), 136'(e.data));
                    chk(count == e.cnt, "count", 136'(count), 136'(e.cnt));
                    chk(win_last == e.last, "win_last", 136'(win_last), 136'(e.last));
                end
            end
            if (!in_ready) begin
                if (stall_run >= 0) stall_run++;
                run_tog = run_tog | toggle_mode;
            end else begin
                if (stall_run > 0 && !run_tog) begin
                    chk(stall_run == BAND, "drain_stall_cycles", 136'(stall_run), 136'(BAND));
                end
                stall_run = 0;
                run_tog   = toggle_mode;
            end
            last_fill_prev = in_valid && in_ready && (fill_beats == BAND - 1);
            if (in_valid && in_ready) fill_beats = (fill_beats + 1) % BAND;
            have_prev  = 1'b1;
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_data  = neuron_out;
            prev_count = count;
            prev_last  = win_last;
        end
        prev_reset = reset;
        if (done) begin
            chk(hs_total == exp_hs, "handshake_total", 136'(hs_total), 136'(exp_hs));
            chk(exp_q.size() == 0, "scoreboard_empty", 136'(exp_q.size()), 136'(0));
            chk(stim_timeouts == 0, "wait_timeouts", 136'(stim_timeouts), 136'(0));
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
        if (mon_cyc > 20000) begin
            chk(1'b0, "global_timeout", 136'(mon_cyc), 136'(20000));
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

endmodule

// File: doc/pool_window_feeder.md
Name: pool_window_feeder

Overview:
- Upstream neighbour of the max-pool node.
- Accepts a raster-order stream of neuron vectors (DEPTH channels × DATA_WIDTH) from the preceding conv/activation stage.
- Buffers one band of KERNAL_SIZE feature-map rows, then replays the band window-by-window, so each non-overlapping KERNAL_SIZE×KERNAL_SIZE window reaches the pool node as consecutive beats with a 1-based element count.
- Stride equals KERNAL_SIZE; windows never overlap.

Parameters:
- KERNAL_SIZE, 2, pooling window edge length; also the stride.
- DEPTH, 8, channels per neuron vector.
- DATA_WIDTH, 16, bits per channel.
- MAP_WIDTH, 8, feature-map row length in vectors; must be a multiple of KERNAL_SIZE (elaboration-time check).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_data  in  DEPTH*DATA_WIDTH  raster-order input vector
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept in_data this cycle
- neuron_out  out  DEPTH*DATA_WIDTH  window element to the pool node
- out_valid  out  1  neuron_out/count valid
- out_ready  in  1  downstream accepts this cycle
- count  out  KERNAL_SIZE**2  element index within window, 1..KERNAL_SIZE**2
- win_last  out  1  high when count == KERNAL_SIZE**2

Behaviour:
- Storage is a band buffer of KERNAL_SIZE*MAP_WIDTH vectors, at address row*MAP_WIDTH + col.
- FSM states:
  - FILL: in_ready=1, out_valid=0. Each beat with in_valid&&in_ready writes in_data at the (row,col) fill counters, then advances col, wrapping to the next row at MAP_WIDTH. When the last beat (row=K-1, col=MAP_WIDTH-1) is accepted, the next state is DRAIN and the fill counters clear.
  - DRAIN: in_ready=0. Drain counters are win (0..MAP_WIDTH/K-1), r (0..K-1) and c (0..K-1), iterated with c fastest, then r, then win. Read address = r*MAP_WIDTH + win*K + c. No dividers or multipliers by non-constants; use counter arithmetic only.
- Output register:
  - neuron_out, count, out_valid and win_last are registered.
  - A new element loads when the output register is empty or out_valid&&out_ready.
  - While out_valid && !out_ready, all outputs hold stable.
- count sequence is 1,2,…,K² per window, row-major within the window; it restarts at 1 on each window.
- Latency: out_valid first rises on the cycle after the final fill beat is accepted. With out_ready held high, one element is emitted per cycle: K*MAP_WIDTH beats, no bubbles.
- Drain completion: when the final element (last window, count=K²) is accepted, the state returns to FILL. in_ready rises that same next cycle, and out_valid falls unless a new element is loaded; none is, since the band is empty.
- No input is accepted during DRAIN. The buffer is single-banked; stalls upstream are expected.
- Reset (synchronous, any state, including mid-fill or mid-drain):
  - State returns to FILL; all counters go to 0.
  - out_valid=0, win_last=0, count=0, neuron_out=0.
  - in_ready=1 on the cycle after reset deasserts.
  - Buffer contents are not cleared. Partial bands are discarded.
- in_valid asserted while in_ready=0 has no effect; upstream must hold its data.
- Simultaneous events: the last fill beat and a drain start cannot overlap. In DRAIN, out_ready toggling arbitrarily must never drop or duplicate an element.

Decomposition:
- Shared package pool_pkg:
  - default KERNAL_SIZE, DEPTH and DATA_WIDTH constants;
  - neuron vector typedef (logic [DEPTH*DATA_WIDTH-1:0]);
  - FSM state enum {FILL, DRAIN}.
- One sub-module, pool_band_buffer: the single-write/single-read register array with write enable, write address, read address and combinational read. The feeder owns the FSM, counters and output register.

Test Plan:
- K=2, DEPTH=1, MAP_WIDTH=4; feed values 1..8, out_ready=1 -> neuron_out sequence 1,2,5,6,3,4,7,8; count 1,2,3,4,1,2,3,4; win_last on beats 4 and 8; out_valid first asserts the cycle after beat 8 is accepted.
- Same config, out_ready toggling 1,0,0,1 pattern -> identical sequence; outputs stable during every stall; exactly 8 handshakes.
- Back-to-back bands (values 1..16, in_valid always 1) -> in_ready=0 for the 8 drain cycles; second band output 9,10,13,14,11,12,15,16.
- Assert reset after 3 fill beats, then feed 8 new values 20..27 -> output 20,21,24,25,22,23,26,27; stale data never emitted.
- Assert reset mid-drain (after 5 outputs) -> next cycle out_valid=0, in_ready=1, count=0; a subsequent full band drains correctly.
- DEPTH=8, DATA_WIDTH=16, channel i = 16'h1000*i + pixel index -> every channel lane follows the per-lane ordering of scenario 1; no lane crossover.
